// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared loader state encoding and boot image constants.
package imem_boot_loader_pkg;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR} loader_state_e;
  localparam int BOOT_BASE_ADDR = 512;
  localparam int LOADER_MAX_WORDS = 128;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream in, instruction memory write port and CPU control out.
interface imem_boot_loader_if #(parameter int AW = 10, parameter int IW = 32);
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          imem_we;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;
  logic [7:0]    words_loaded;
  modport master (
    input  byte_data, byte_valid,
    output byte_ready, imem_addr, imem_wdata, imem_we, cpu_reset, load_done, load_error, words_loaded
  );
  modport slave (
    output byte_data, byte_valid,
    input  byte_ready, imem_addr, imem_wdata, imem_we, cpu_reset, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// byte_word_assembler: packs four little-endian stream bytes into one 32-bit word.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0]  idx_q;
  logic [31:0] word_q;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (load) begin
      idx_q               <= idx_q + 2'd1;
      word_q[8*idx_q +: 8] <= data;
    end
  end
  assign word      = word_q;
  assign word_full = load && idx_q == 2'd3;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed image into instruction memory, then releases the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = 10,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int BASE_ADDR         = BOOT_BASE_ADDR,
  parameter int MAX_WORDS         = LOADER_MAX_WORDS,
  parameter int RELEASE_DELAY     = 4
) (
  input logic                clk,
  input logic                reset,
  imem_boot_loader_if.master bus
);
  localparam int RW = $clog2(RELEASE_DELAY + 1);
  loader_state_e state_q, state_d;
  logic [15:0]   count_q, count_d, hdr;
  logic [7:0]    words_q, words_d;
  logic [RW-1:0] rel_q, rel_d;
  logic          ready_q, cpu_reset_q, cpu_reset_d, done_q, done_d;
  logic          take, last, word_full;
  logic [31:0]   word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e TAIL = CSUM;
  logic [7:0] csum_q, csum_d;
  assign csum_d = take && state_q inside {LEN_LO, LEN_HI, DATA} ? csum_q ^ bus.byte_data : csum_q;
`else
  localparam loader_state_e TAIL = DONE;
`endif
  assign take = bus.byte_valid && ready_q;
  assign hdr  = {bus.byte_data, count_q[7:0]};
  assign last = {8'd0, words_q} + 16'd1 == count_q;
  byte_word_assembler u_asm (
    .clk       (clk),
    .rst       (reset),
    .load      (take && state_q == DATA),
    .clear     (state_q == LEN_LO),
    .data      (bus.byte_data),
    .word      (word),
    .word_full (word_full)
  );
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    words_d     = words_q;
    rel_d       = rel_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    unique case (state_q)
      LEN_LO: if (take) begin
        count_d[7:0] = bus.byte_data;
        state_d      = LEN_HI;
      end
      LEN_HI: if (take) begin
        count_d = hdr;
        state_d = hdr > 16'(MAX_WORDS) ? ERROR : hdr == 16'd0 ? TAIL : DATA;
      end
      DATA: state_d = word_full ? WRITE : DATA;
      WRITE: begin
        words_d = words_q + 8'd1;
        state_d = last ? TAIL : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (take) state_d = bus.byte_data == csum_q ? DONE : ERROR;
`endif
      // The CPU leaves reset on the same edge load_done rises.
      DONE: if (cpu_reset_q) begin
        if (rel_q == RW'(RELEASE_DELAY - 1)) begin
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
        end else rel_d = rel_q + RW'(1);
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LEN_LO;
      count_q     <= '0;
      words_q     <= '0;
      rel_q       <= '0;
      ready_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      words_q     <= words_d;
      rel_q       <= rel_d;
      ready_q     <= state_d inside {LEN_LO, LEN_HI, DATA, CSUM};
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end
  assign bus.byte_ready   = ready_q;
  assign bus.imem_we      = state_q == WRITE;
  assign bus.imem_addr    = ADDRESS_BUS_WIDTH'(BASE_ADDR) + ADDRESS_BUS_WIDTH'({words_q, 2'b00});
  assign bus.imem_wdata   = INSTRUCTION_WIDTH'(word);
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.load_done    = done_q;
  assign bus.load_error   = state_q == ERROR;
  assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed stimulus for imem_boot_loader with hand-computed expectations.
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0, n_cmp = 0, n_bad = 0, nw = 0, low_cnt = 0, last_acc = 0;
  int n0, n1, lc, e, tail;
  int wt [64];
  logic [9:0]  wa [64];
  logic [31:0] wd [64];
  logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  imem_boot_loader_if bus ();
  imem_boot_loader dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.imem_we && nw < 64) begin
      wa[nw] = bus.imem_addr;
      wd[nw] = bus.imem_wdata;
      wt[nw] = cyc;
      nw++;
    end
    if (!bus.cpu_reset) low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'hEE;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    while (!bus.byte_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("byte_accept", bus.byte_ready, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_release(output int edge_n);
    int t = 0;
    while (bus.cpu_reset && t < 40) begin
      @(negedge clk);
      t++;
    end
    edge_n = cyc;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_we", bus.imem_we, 0);
    chk("rst_addr", bus.imem_addr, 32'h200);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    chk("rst_done", bus.load_done, 0);
    chk("rst_error", bus.load_error, 0);
    chk("rst_words", bus.words_loaded, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", bus.byte_ready, 1);

    // two-word image, valid every cycle
    n0 = nw;
    foreach (img[i]) send(img[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h11, 1'b0);
`endif
    wait_release(e);
    chk("t1_nwrites", nw - n0, 2);
    chk("t1_addr0", wa[n0], 32'h200);
    chk("t1_data0", wd[n0], 32'h00000013);
    chk("t1_addr1", wa[n0+1], 32'h204);
    chk("t1_data1", wd[n0+1], 32'hDDCCBBAA);
    chk("t1_words", bus.words_loaded, 2);
    chk("t1_done", bus.load_done, 1);
    chk("t1_cpu_reset", bus.cpu_reset, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    tail = last_acc;
`else
    tail = wt[n0+1] + 1;
`endif
    chk("t1_release_delay", e - tail, 4);

    // bytes offered after DONE are refused
    bus.byte_data  = 8'h5A;
    bus.byte_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    chk("post_done_ready", bus.byte_ready, 0);
    chk("post_done_nwrites", nw - n0, 2);
    chk("post_done_words", bus.words_loaded, 2);
    chk("post_done_done", bus.load_done, 1);

    // empty image
    pulse_reset();
    chk("rearm_cpu_reset", bus.cpu_reset, 1);
    chk("rearm_done", bus.load_done, 0);
    n0 = nw;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 1'b0);
`endif
    tail = last_acc;
    wait_release(e);
    chk("t2_release_delay", e - tail, 4);
    chk("t2_nwrites", nw - n0, 0);
    chk("t2_done", bus.load_done, 1);
    chk("t2_words", bus.words_loaded, 0);

    // count == MAX_WORDS is accepted
    pulse_reset();
    send(8'h80, 1'b0);
    send(8'h00, 1'b0);
    chk("max_error", bus.load_error, 0);
    chk("max_ready", bus.byte_ready, 1);

    // count == MAX_WORDS+1 is rejected
    pulse_reset();
    send(8'h81, 1'b0);
    send(8'h00, 1'b0);
    chk("t3_error", bus.load_error, 1);
    chk("t3_ready", bus.byte_ready, 0);
    chk("t3_cpu_reset", bus.cpu_reset, 1);
    lc = low_cnt;
    n0 = nw;
    bus.byte_data  = 8'h13;
    bus.byte_valid = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    chk("t3_cpu_held", low_cnt - lc, 0);
    chk("t3_nwrites", nw - n0, 0);
    chk("t3_error_sticky", bus.load_error, 1);

    // gappy stream, aborted by reset after the first word, then restarted
    pulse_reset();
    lc = low_cnt;
    n0 = nw;
    for (int i = 0; i < 6; i++) send(img[i], 1'b1);
    @(posedge clk);
    #1;
    chk("t4_words_first", bus.words_loaded, 1);
    chk("t4_nwrites_first", nw - n0, 1);
    send(img[6], 1'b1);
    pulse_reset();
    chk("t4_words_cleared", bus.words_loaded, 0);
    chk("t4_cpu_reset", bus.cpu_reset, 1);
    chk("t4_ready_cleared", bus.byte_ready, 0);
    chk("t4_cpu_held", low_cnt - lc, 0);
    n1 = nw;
    foreach (img[i]) send(img[i], 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h11, 1'b1);
`endif
    wait_release(e);
    chk("t4_nwrites", nw - n1, 2);
    chk("t4_addr0", wa[n1], 32'h200);
    chk("t4_data0", wd[n1], 32'h00000013);
    chk("t4_addr1", wa[n1+1], 32'h204);
    chk("t4_data1", wd[n1+1], 32'hDDCCBBAA);
    chk("t4_words", bus.words_loaded, 2);
    chk("t4_done", bus.load_done, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_reset();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 2; i < 6; i++) send(img[i], 1'b0);
    send(8'h12, 1'b0);
    wait_release(e);
    chk("cs_good_done", bus.load_done, 1);
    chk("cs_good_error", bus.load_error, 0);
    pulse_reset();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 2; i < 6; i++) send(img[i], 1'b0);
    send(8'h13, 1'b0);
    chk("cs_bad_error", bus.load_error, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("cs_bad_cpu_reset", bus.cpu_reset, 1);
    chk("cs_bad_done", bus.load_done, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
